// File: rtl/test_io_pipe.sv
// test_io_pipe: parametrised bring-up / loopback pipe between board I/O and
// DUT logic. NBIT bit lines and NCH words of WIDTH bits pass through DEPTH-1
// pipe stages, then an output stage selected by MODE
// (PASS / HOLD / PEAK / PATTERN) with a saturating sample counter.
// Optional feature macro: TEST_IO_PATTERN_EN builds the test-pattern
// generator. Without it, MODE=3 behaves exactly like PASS.
module test_io_pipe #(
  parameter int NBIT   = 8,
  parameter int NCH    = 4,
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 2,
  parameter int SIGNED = 1,
  parameter int CNTW   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NBIT-1:0]       IN_BITS,
  input  logic [NCH*WIDTH-1:0]  IN_DATA,
  input  logic                  IN_VALID,
  input  logic [1:0]            MODE,
  input  logic                  CLR,
  output logic [NBIT-1:0]       OUT_BITS,
  output logic [NCH*WIDTH-1:0]  OUT_DATA,
  output logic                  OUT_VALID,
  output logic [CNTW-1:0]       OUT_CNT
);

  localparam int DW = NCH * WIDTH;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_PEAK = 2'd2,
    MODE_PAT  = 2'd3
  } mode_e;

  logic            tail_v;
  logic [NBIT-1:0] tail_b;
  logic [DW-1:0]   tail_d;

  generate
    if (DEPTH <= 1) begin : g_nopipe
      assign tail_v = IN_VALID;
      assign tail_b = IN_BITS;
      assign tail_d = IN_DATA;
    end else begin : g_pipe
      localparam int PS = DEPTH - 1;
      logic [PS-1:0]           pv_q, pv_d;
      logic [PS-1:0][NBIT-1:0] pb_q, pb_d;
      logic [PS-1:0][DW-1:0]   pd_q, pd_d;

      // Shift register; a clear only kills the valids, payload stays put.
      always_comb begin
        pv_d = pv_q;
        pb_d = pb_q;
        pd_d = pd_q;
        if (CLR) begin
          pv_d = '0;
        end else begin
          pv_d[0] = IN_VALID;
          pb_d[0] = IN_BITS;
          pd_d[0] = IN_DATA;
          for (int i = 1; i < PS; i++) begin
            pv_d[i] = pv_q[i-1];
            pb_d[i] = pb_q[i-1];
            pd_d[i] = pd_q[i-1];
          end
        end
      end

      // Pipe stage registers.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          pv_q <= '0;
          pb_q <= '0;
          pd_q <= '0;
        end else begin
          pv_q <= pv_d;
          pb_q <= pb_d;
          pd_q <= pd_d;
        end
      end

      assign tail_v = pv_q[PS-1];
      assign tail_b = pb_q[PS-1];
      assign tail_d = pd_q[PS-1];
    end
  endgenerate

  logic [NBIT-1:0] bits_q, bits_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            peak_init_q, peak_init_d;

`ifdef TEST_IO_PATTERN_EN
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [NBIT-1:0]  pat_bits;

  // Pattern bit lines: low bits of pcnt, zero-extended when NBIT > WIDTH.
  for (genvar i = 0; i < NBIT; i++) begin : g_pat_bits
    if (i < WIDTH) begin : g_src
      assign pat_bits[i] = pcnt_q[i];
    end else begin : g_zero
      assign pat_bits[i] = 1'b0;
    end
  end
`endif

  function automatic logic [WIDTH-1:0] peak_max(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] nxt);
    logic gt;
    if (SIGNED != 0) gt = $signed(nxt) > $signed(cur);
    else             gt = nxt > cur;
    return gt ? nxt : cur;
  endfunction

  // Output stage next-state: clear first, then the MODE behaviour.
  always_comb begin
    bits_d      = bits_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    cnt_d       = cnt_q;
    peak_init_d = peak_init_q;
`ifdef TEST_IO_PATTERN_EN
    pcnt_d      = pcnt_q;
`endif
    if (CLR) begin
      bits_d      = '0;
      data_d      = '0;
      cnt_d       = '0;
      peak_init_d = 1'b1;
`ifdef TEST_IO_PATTERN_EN
      pcnt_d      = '0;
`endif
    end else begin
      // Any cycle outside PEAK re-arms peak_init, so entering PEAK loads
      // the first valid tail sample directly.
      case (mode_e'(MODE))
        MODE_HOLD: begin
          peak_init_d = 1'b1;
        end
        MODE_PEAK: begin
          valid_d = tail_v;
          if (tail_v) begin
            if (peak_init_q) begin
              bits_d = tail_b;
              data_d = tail_d;
            end else begin
              bits_d = bits_q | tail_b;
              for (int c = 0; c < NCH; c++) begin
                data_d[c*WIDTH +: WIDTH] = peak_max(data_q[c*WIDTH +: WIDTH],
                                                    tail_d[c*WIDTH +: WIDTH]);
              end
            end
            peak_init_d = 1'b0;
          end
        end
`ifdef TEST_IO_PATTERN_EN
        MODE_PAT: begin
          valid_d     = 1'b1;
          bits_d      = pat_bits;
          pcnt_d      = pcnt_q + 1'b1;
          peak_init_d = 1'b1;
          for (int c = 0; c < NCH; c++) begin
            data_d[c*WIDTH +: WIDTH] = pcnt_q + WIDTH'(c);
          end
        end
`endif
        default: begin
          valid_d     = tail_v;
          peak_init_d = 1'b1;
          if (tail_v) begin
            bits_d = tail_b;
            data_d = tail_d;
          end
        end
      endcase
      if (valid_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  // Output stage registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bits_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      peak_init_q <= 1'b1;
`ifdef TEST_IO_PATTERN_EN
      pcnt_q      <= '0;
`endif
    end else begin
      bits_q      <= bits_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      peak_init_q <= peak_init_d;
`ifdef TEST_IO_PATTERN_EN
      pcnt_q      <= pcnt_d;
`endif
    end
  end

  assign OUT_BITS  = bits_q;
  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign OUT_CNT   = cnt_q;

endmodule

// File: tb/tb_test_io_pipe.sv
// Bench for test_io_pipe: two instances share stimulus, one signed with a
// 16-bit counter, one unsigned with a 4-bit counter.
module tb_test_io_pipe;
  logic        CLK = 1'b0;
  logic        RST_N, IN_VALID, CLR;
  logic [7:0]  IN_BITS;
  logic [63:0] IN_DATA;
  logic [1:0]  MODE;

  logic [7:0]  bits_a, bits_b;
  logic [63:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [7:0]  bits_a;
    logic [63:0] data_a;
    logic [7:0]  bits_b;
    logic [63:0] data_b;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  test_io_pipe #(.NBIT(8), .NCH(4), .WIDTH(16), .DEPTH(2), .SIGNED(1), .CNTW(16)) u_dut_a (
    .CLK(CLK), .RST_N(RST_N), .IN_BITS(IN_BITS), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .MODE(MODE), .CLR(CLR), .OUT_BITS(bits_a), .OUT_DATA(data_a), .OUT_VALID(valid_a),
    .OUT_CNT(cnt_a));

  test_io_pipe #(.NBIT(8), .NCH(4), .WIDTH(16), .DEPTH(2), .SIGNED(0), .CNTW(4)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N), .IN_BITS(IN_BITS), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .MODE(MODE), .CLR(CLR), .OUT_BITS(bits_b), .OUT_DATA(data_b), .OUT_VALID(valid_b),
    .OUT_CNT(cnt_b));

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CLR = 1'b0; MODE = 2'd0;
    IN_VALID = 1'b0; IN_BITS = '0; IN_DATA = '0;
    #12;
    vecs++;
    if (bits_a !== 8'h0 || data_a !== 64'h0 || valid_a !== 1'b0 || cnt_a !== 16'h0 || cnt_b !== 4'h0) begin
      errs++;
      $display("FAIL reset: bits=%h data=%h valid=%b cnt_a=%h cnt_b=%h, want all 0",
               bits_a, data_a, valid_a, cnt_a, cnt_b);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_pass();
    sb.delete();
    MODE = 2'd0;
    for (int i = 0; i < 8; i++) begin
      IN_VALID = (i < 6);
      IN_BITS  = (i == 0) ? 8'h5A : 8'($urandom);
      IN_DATA  = (i == 0) ? 64'h1234 : {$urandom, $urandom};
      if (i < 6) sb.push_back('{IN_BITS, IN_DATA, IN_BITS, IN_DATA});
      step();
      if (i == 0) begin
        vecs++;
        if (valid_a !== 1'b0) begin
          errs++;
          $display("FAIL pass_latency: valid=%b after 1 edge, want 0", valid_a);
        end
      end
      if (valid_a) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL pass_sb: unexpected output data=%h", data_a);
        end else begin
          e = sb.pop_front();
          if (data_a !== e.data_a || bits_a !== e.bits_a || data_b !== e.data_b || bits_b !== e.bits_b) begin
            errs++;
            $display("FAIL pass_sb: got a %h/%h b %h/%h, want a %h/%h b %h/%h",
                     data_a, bits_a, data_b, bits_b, e.data_a, e.bits_a, e.data_b, e.bits_b);
          end
        end
      end
    end
    vecs++;
    if (sb.size() != 0 || cnt_a !== 16'd6 || cnt_b !== 4'd6 || valid_a !== 1'b0) begin
      errs++;
      $display("FAIL pass_end: left=%0d cnt_a=%0d cnt_b=%0d valid=%b, want 0 6 6 0",
               sb.size(), cnt_a, cnt_b, valid_a);
    end
  endtask

  task automatic test_hold();
    MODE = 2'd0; IN_VALID = 1'b1; IN_BITS = 8'h3C;
    IN_DATA = 64'h0000_0000_00AA_0000;
    step(); step();
    vecs++;
    if (data_a[31:16] !== 16'h00AA || cnt_a !== 16'd7) begin
      errs++;
      $display("FAIL hold_pre: ch1=%h cnt=%0d, want 00aa 7", data_a[31:16], cnt_a);
    end
    MODE = 2'd1; IN_DATA = {4{16'h5555}}; IN_BITS = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      vecs++;
      if (data_a[31:16] !== 16'h00AA || bits_a !== 8'h3C || valid_a !== 1'b0 || cnt_a !== 16'd7) begin
        errs++;
        $display("FAIL hold: ch1=%h bits=%h valid=%b cnt=%0d, want 00aa 3c 0 7",
                 data_a[31:16], bits_a, valid_a, cnt_a);
      end
    end
    MODE = 2'd0; IN_VALID = 1'b0;
    step(); step();
    vecs++;
    if (data_a !== {4{16'h5555}} || cnt_a !== 16'd8 || cnt_b !== 4'd8) begin
      errs++;
      $display("FAIL hold_exit: data=%h cnt_a=%0d cnt_b=%0d, want 5555x4 8 8", data_a, cnt_a, cnt_b);
    end
  endtask

  task automatic test_peak();
    logic [15:0] pk_in [4];
    logic [7:0]  pk_bits [4];
    logic [15:0] exp_s [4];
    pk_in   = '{16'hFFF0, 16'h0005, 16'h8000, 16'h0003};
    pk_bits = '{8'h01, 8'h80, 8'h00, 8'h00};
    exp_s   = '{16'hFFF0, 16'h0005, 16'h0005, 16'h0005};
    sb.delete();
    CLR = 1'b1; step(); CLR = 1'b0;
    MODE = 2'd2;
    for (int i = 0; i < 6; i++) begin
      IN_VALID = (i < 4);
      IN_DATA  = (i < 4) ? {16'h0, pk_in[i], 32'h0} : {16'h0, 16'h7FFF, 32'h0};
      IN_BITS  = (i < 4) ? pk_bits[i] : 8'h7E;
      if (i < 4) sb.push_back('{(i == 0) ? 8'h01 : 8'h81, {16'h0, exp_s[i], 32'h0},
                                (i == 0) ? 8'h01 : 8'h81, {16'h0, 16'hFFF0, 32'h0}});
      step();
      if (valid_a) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL peak_sb: unexpected output data=%h", data_a);
        end else begin
          e = sb.pop_front();
          if (data_a !== e.data_a || bits_a !== e.bits_a || data_b !== e.data_b || bits_b !== e.bits_b) begin
            errs++;
            $display("FAIL peak_sb: got a %h/%h b %h/%h, want a %h/%h b %h/%h",
                     data_a, bits_a, data_b, bits_b, e.data_a, e.bits_a, e.data_b, e.bits_b);
          end
        end
      end
    end
    vecs++;
    if (sb.size() != 0 || valid_a !== 1'b0 || data_a[47:32] !== 16'h0005 || data_b[47:32] !== 16'hFFF0
        || bits_a !== 8'h81 || cnt_a !== 16'd4) begin
      errs++;
      $display("FAIL peak_end: left=%0d valid=%b a=%h b=%h bits=%h cnt=%0d, want 0 0 0005 fff0 81 4",
               sb.size(), valid_a, data_a[47:32], data_b[47:32], bits_a, cnt_a);
    end
    #2;
    RST_N = 1'b0;
    #1;
    vecs++;
    if (bits_a !== 8'h0 || data_a !== 64'h0 || data_b !== 64'h0 || valid_a !== 1'b0 || cnt_a !== 16'h0) begin
      errs++;
      $display("FAIL async_reset: bits=%h data=%h valid=%b cnt=%0d, want all 0",
               bits_a, data_a, valid_a, cnt_a);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_sat_clear();
    sb.delete();
    MODE = 2'd0;
    for (int i = 0; i < 22; i++) begin
      IN_VALID = (i < 20);
      IN_BITS  = 8'(i);
      IN_DATA  = {4{16'(i + 1)}};
      if (i < 20) sb.push_back('{IN_BITS, IN_DATA, IN_BITS, IN_DATA});
      step();
      if (valid_a) begin
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL sat_sb: unexpected output data=%h", data_a);
        end else begin
          e = sb.pop_front();
          if (data_a !== e.data_a || bits_a !== e.bits_a || data_b !== e.data_b || bits_b !== e.bits_b) begin
            errs++;
            $display("FAIL sat_sb: got a %h/%h b %h/%h, want a %h/%h b %h/%h",
                     data_a, bits_a, data_b, bits_b, e.data_a, e.bits_a, e.data_b, e.bits_b);
          end
        end
      end
    end
    vecs++;
    if (cnt_a !== 16'd20 || cnt_b !== 4'd15) begin
      errs++;
      $display("FAIL saturate: cnt_a=%0d cnt_b=%0d, want 20 15", cnt_a, cnt_b);
    end
    IN_VALID = 1'b1; IN_DATA = {4{16'hBEEF}}; IN_BITS = 8'hA5;
    step();
    CLR = 1'b1;
    step();
    vecs++;
    if (bits_a !== 8'h0 || data_a !== 64'h0 || valid_a !== 1'b0 || cnt_a !== 16'h0 || cnt_b !== 4'h0) begin
      errs++;
      $display("FAIL clear: bits=%h data=%h valid=%b cnt_a=%0d cnt_b=%0d, want all 0",
               bits_a, data_a, valid_a, cnt_a, cnt_b);
    end
    CLR = 1'b0; IN_VALID = 1'b0;
    step();
    vecs++;
    if (valid_a !== 1'b0 || cnt_a !== 16'h0 || data_a !== 64'h0) begin
      errs++;
      $display("FAIL clear_pipe: valid=%b cnt=%0d data=%h, want 0 0 0", valid_a, cnt_a, data_a);
    end
  endtask

  task automatic test_pattern();
    logic [63:0] exp_d [3];
    logic [7:0]  exp_b [3];
    exp_d = '{64'h0003_0002_0001_0000, 64'h0004_0003_0002_0001, 64'h0005_0004_0003_0002};
    exp_b = '{8'h00, 8'h01, 8'h02};
    CLR = 1'b1; step(); CLR = 1'b0;
    IN_VALID = 1'b0; IN_DATA = {4{16'h7777}}; IN_BITS = 8'h77;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        MODE = 2'd1;
        step();
      end
      MODE = 2'd3;
      step();
      vecs++;
`ifdef TEST_IO_PATTERN_EN
      if (data_a !== exp_d[i] || bits_a !== exp_b[i] || valid_a !== 1'b1 || cnt_a !== 16'(i + 1)) begin
        errs++;
        $display("FAIL pattern: data=%h bits=%h valid=%b cnt=%0d, want %h %h 1 %0d",
                 data_a, bits_a, valid_a, cnt_a, exp_d[i], exp_b[i], i + 1);
      end
`else
      if (data_a !== 64'h0 || bits_a !== 8'h0 || valid_a !== 1'b0 || cnt_a !== 16'h0) begin
        errs++;
        $display("FAIL pattern_off: data=%h bits=%h valid=%b cnt=%0d, want 0 0 0 0 (pass, no valid)",
                 data_a, bits_a, valid_a, cnt_a);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_hold();
    test_peak();
    test_sat_clear();
    test_pattern();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
